id_hazard_forward_unit: RTL and testbench

//  Parametrised ID-stage forwarding and stall controller; next generation of the single-level ID forwarding logic.
//  For each ID source operand, picks the youngest in-flight producer among NUM_STAGES downstream stages.

---
 rtl/id_hazard_forward_unit_if.sv | 33 +++
 rtl/id_hazard_forward_unit.sv | 110 +++++++++++
 tb/tb_id_hazard_forward_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_forward_unit_if.sv
// Bundle between the ID stage / downstream pipeline stages and the
// hazard/forward unit. The pipeline side drives the master modport, the
// unit uses the slave modport.
interface id_hazard_forward_unit_if #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int AW         = 5,
  parameter int CNT_W      = 32
);
  localparam int SELW = $clog2(NUM_STAGES + 1);

  logic                       id_valid;
  logic [NUM_SRC*AW-1:0]      id_src_addr;
  logic [NUM_SRC-1:0]         id_src_used;
  logic [NUM_STAGES-1:0]      stg_wr_en;
  logic [NUM_STAGES*AW-1:0]   stg_wr_addr;
  logic [NUM_STAGES-1:0]      stg_rdy;
  logic [NUM_SRC*SELW-1:0]    fwd_sel;
  logic                       stall;
  logic                       bubble;
  logic                       hazard_err;
  logic [CNT_W-1:0]           stall_total;

  modport master (
    output id_valid, id_src_addr, id_src_used, stg_wr_en, stg_wr_addr, stg_rdy,
    input  fwd_sel, stall, bubble, hazard_err, stall_total
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_used, stg_wr_en, stg_wr_addr, stg_rdy,
    output fwd_sel, stall, bubble, hazard_err, stall_total
  );
endinterface

// File: rtl/id_hazard_forward_unit.sv
// ID-stage forwarding and stall controller. For every source operand the
// youngest in-flight writer of the same register is selected; if that writer
// cannot forward yet, ID stalls. Stall episodes are tracked by a RUN/STALL
// FSM with a consecutive-stall watchdog and a saturating stall counter.
module id_hazard_forward_unit #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int AW         = 5,
  parameter int MAX_STALL  = 4,
  parameter int CNT_W      = 32
) (
  input  logic                    Clk,
  input  logic                    Rst,
  id_hazard_forward_unit_if.slave bus
);
  localparam int SELW = $clog2(NUM_STAGES + 1);
  // run counter only needs to reach MAX_STALL+1 to flag the overrun
  localparam int RUNW = $clog2(MAX_STALL + 2);
  localparam logic [RUNW-1:0] RUN_SAT = RUNW'(MAX_STALL + 1);
  localparam logic [RUNW-1:0] RUN_MAX = RUNW'(MAX_STALL);

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [RUNW-1:0]         r_run_cnt;
  logic [RUNW-1:0]         w_run_next;
  logic                    r_hazard_err;
  logic [CNT_W-1:0]        r_stall_total;
  logic [NUM_SRC*SELW-1:0] w_fwd_sel;
  logic [NUM_SRC-1:0]      w_haz;
  logic                    w_found;
  logic                    w_stall;
  logic                    w_err_set;

  function automatic logic [CNT_W-1:0] sat_inc_total(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUNW-1:0] sat_inc_run(input logic [RUNW-1:0] v);
    return (v >= RUN_SAT) ? RUN_SAT : v + RUNW'(1);
  endfunction

  // Per operand: first (youngest) matching writer decides forward vs hazard
  always_comb begin
    w_fwd_sel = '0;
    w_haz     = '0;
    w_found   = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      w_found = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (!w_found && bus.id_src_used[j] &&
            (bus.id_src_addr[j*AW +: AW] != '0) && bus.stg_wr_en[i] &&
            (bus.stg_wr_addr[i*AW +: AW] == bus.id_src_addr[j*AW +: AW])) begin
          w_found = 1'b1;
          if (bus.stg_rdy[i]) w_fwd_sel[j*SELW +: SELW] = SELW'(i + 1);
          else                w_haz[j] = 1'b1;
        end
      end
    end
    if (!bus.id_valid || Rst) begin
      w_fwd_sel = '0;
      w_haz     = '0;
    end
  end

  assign w_stall = |w_haz;

  // Next state and consecutive-stall count
  always_comb begin
    w_state_next = r_state;
    w_run_next   = '0;
    case (r_state)
      ST_RUN: begin
        if (w_stall) begin
          w_state_next = ST_STALL;
          w_run_next   = RUNW'(1);
        end
      end
      ST_STALL: begin
        if (w_stall) w_run_next = sat_inc_run(r_run_cnt);
        else         w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign w_err_set = (w_run_next > RUN_MAX);

  // State register, sticky watchdog flag and saturating stall counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= ST_RUN;
      r_run_cnt     <= '0;
      r_hazard_err  <= 1'b0;
      r_stall_total <= '0;
    end else begin
      r_state   <= w_state_next;
      r_run_cnt <= w_run_next;
      if (w_err_set) r_hazard_err  <= 1'b1;
      if (w_stall)   r_stall_total <= sat_inc_total(r_stall_total);
    end
  end

  assign bus.fwd_sel     = w_fwd_sel;
  assign bus.stall       = w_stall;
  assign bus.bubble      = w_stall;
  assign bus.hazard_err  = r_hazard_err;
  assign bus.stall_total = r_stall_total;
endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Directed bench for id_hazard_forward_unit: default instance plus a
// CNT_W=4 instance driven identically to exercise counter saturation.
module tb_id_hazard_forward_unit;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  id_hazard_forward_unit_if bus ();
  id_hazard_forward_unit_if #(.CNT_W(4)) bus4 ();

  id_hazard_forward_unit dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  id_hazard_forward_unit #(.CNT_W(4)) dut4 (.Clk(Clk), .Rst(Rst), .bus(bus4));

  task automatic drive(input logic v, input logic [9:0] a, input logic [1:0] u,
                       input logic [2:0] we, input logic [14:0] wa, input logic [2:0] r);
    bus.id_valid  = v;  bus.id_src_addr  = a;  bus.id_src_used  = u;
    bus.stg_wr_en = we; bus.stg_wr_addr  = wa; bus.stg_rdy      = r;
    bus4.id_valid = v;  bus4.id_src_addr = a;  bus4.id_src_used = u;
    bus4.stg_wr_en = we; bus4.stg_wr_addr = wa; bus4.stg_rdy    = r;
  endtask

  task automatic idle();
    drive(1'b0, 10'd0, 2'b00, 3'b000, 15'd0, 3'b000);
  endtask

  // load of r7 still in EX, operand 1 reads r7
  task automatic hazard();
    drive(1'b1, {5'd7, 5'd0}, 2'b10, 3'b001, {10'd0, 5'd7}, 3'b000);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    idle();
    step();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    hazard();
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
    checks++; if (bus.bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble: got %b want 0", bus.bubble); end
    checks++; if (bus.fwd_sel !== 4'h0) begin errors++; $display("FAIL rst_fwd: got %h want 0", bus.fwd_sel); end
    step();
    checks++; if (bus.hazard_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.hazard_err); end
    checks++; if (bus.stall_total !== 32'd0) begin errors++; $display("FAIL rst_total: got %0d want 0", bus.stall_total); end
    checks++; if (bus4.stall_total !== 4'd0) begin errors++; $display("FAIL rst_total4: got %0d want 0", bus4.stall_total); end
    Rst = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rst_release_stall: got %b want 1", bus.stall); end
    idle();
    step();
  endtask

  task automatic test_youngest();
    drive(1'b1, {5'd0, 5'd3}, 2'b01, 3'b101, {5'd3, 5'd0, 5'd3}, 3'b101);
    #1;
    checks++; if (bus.fwd_sel !== 4'b0001) begin errors++; $display("FAIL young_fwd: got %h want 1", bus.fwd_sel); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL young_stall: got %b want 0", bus.stall); end
    drive(1'b1, {5'd0, 5'd3}, 2'b01, 3'b101, {5'd3, 5'd0, 5'd3}, 3'b100);
    #1;
    checks++; if (bus.fwd_sel !== 4'b0000) begin errors++; $display("FAIL nofallback_fwd: got %h want 0", bus.fwd_sel); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL nofallback_stall: got %b want 1", bus.stall); end
    drive(1'b0, {5'd0, 5'd3}, 2'b01, 3'b101, {5'd3, 5'd0, 5'd3}, 3'b100);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL novalid_stall: got %b want 0", bus.stall); end
    drive(1'b0, {5'd0, 5'd3}, 2'b01, 3'b101, {5'd3, 5'd0, 5'd3}, 3'b101);
    #1;
    checks++; if (bus.fwd_sel !== 4'b0000) begin errors++; $display("FAIL novalid_fwd: got %h want 0", bus.fwd_sel); end
    drive(1'b1, {5'd0, 5'd3}, 2'b01, 3'b100, {5'd3, 5'd0, 5'd3}, 3'b100);
    #1;
    checks++; if (bus.fwd_sel !== 4'b0011) begin errors++; $display("FAIL oldest_fwd: got %h want 3", bus.fwd_sel); end
    idle();
    step();
  endtask

  task automatic test_reg0();
    drive(1'b1, {5'd0, 5'd0}, 2'b01, 3'b001, 15'd0, 3'b000);
    #1;
    checks++; if (bus.fwd_sel !== 4'b0000) begin errors++; $display("FAIL reg0_fwd: got %h want 0", bus.fwd_sel); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reg0_stall: got %b want 0", bus.stall); end
    drive(1'b1, {5'd0, 5'd3}, 2'b00, 3'b001, {10'd0, 5'd3}, 3'b001);
    #1;
    checks++; if (bus.fwd_sel !== 4'b0000) begin errors++; $display("FAIL unused_fwd: got %h want 0", bus.fwd_sel); end
    idle();
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    hazard();
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
    checks++; if (bus.bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b want 1", bus.bubble); end
    checks++; if (bus.fwd_sel !== 4'b0000) begin errors++; $display("FAIL lu_fwd: got %h want 0", bus.fwd_sel); end
    step();
    drive(1'b1, {5'd7, 5'd0}, 2'b10, 3'b010, {5'd0, 5'd7, 5'd0}, 3'b010);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu2_stall: got %b want 0", bus.stall); end
    checks++; if (bus.fwd_sel !== 4'b1000) begin errors++; $display("FAIL lu2_fwd: got %h want 8", bus.fwd_sel); end
    checks++; if (bus.stall_total !== 32'd1) begin errors++; $display("FAIL lu_total: got %0d want 1", bus.stall_total); end
    idle();
    step();
    checks++; if (bus.stall_total !== 32'd1) begin errors++; $display("FAIL lu_total_hold: got %0d want 1", bus.stall_total); end
    checks++; if (bus.hazard_err !== 1'b0) begin errors++; $display("FAIL lu_err: got %b want 0", bus.hazard_err); end
  endtask

  task automatic test_same_stage();
    drive(1'b1, {5'd4, 5'd4}, 2'b11, 3'b010, {5'd0, 5'd4, 5'd0}, 3'b010);
    #1;
    checks++; if (bus.fwd_sel !== 4'b1010) begin errors++; $display("FAIL same_fwd: got %h want a", bus.fwd_sel); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL same_stall: got %b want 0", bus.stall); end
    drive(1'b1, {5'd4, 5'd2}, 2'b01, 3'b001, {10'd0, 5'd4}, 3'b000);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL unused_stall: got %b want 0", bus.stall); end
    drive(1'b1, {5'd4, 5'd2}, 2'b11, 3'b011, {5'd0, 5'd2, 5'd4}, 3'b010);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mixed_stall: got %b want 1", bus.stall); end
    checks++; if (bus.fwd_sel !== 4'b0010) begin errors++; $display("FAIL mixed_fwd: got %h want 2", bus.fwd_sel); end
    idle();
    step();
  endtask

  task automatic test_watchdog();
    do_reset();
    hazard();
    repeat (4) step();
    checks++; if (bus.hazard_err !== 1'b0) begin errors++; $display("FAIL wd4_err: got %b want 0", bus.hazard_err); end
    checks++; if (bus.stall_total !== 32'd4) begin errors++; $display("FAIL wd4_total: got %0d want 4", bus.stall_total); end
    step();
    checks++; if (bus.hazard_err !== 1'b1) begin errors++; $display("FAIL wd5_err: got %b want 1", bus.hazard_err); end
    checks++; if (bus.stall_total !== 32'd5) begin errors++; $display("FAIL wd5_total: got %0d want 5", bus.stall_total); end
    checks++; if (bus4.stall_total !== 4'd5) begin errors++; $display("FAIL wd5_total4: got %0d want 5", bus4.stall_total); end
    idle();
    step();
    checks++; if (bus.hazard_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", bus.hazard_err); end
    checks++; if (bus.stall_total !== 32'd5) begin errors++; $display("FAIL wd_total_hold: got %0d want 5", bus.stall_total); end
  endtask

  task automatic test_reset_mid_stall();
    hazard();
    step();
    Rst = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rms_stall: got %b want 0", bus.stall); end
    checks++; if (bus.bubble !== 1'b0) begin errors++; $display("FAIL rms_bubble: got %b want 0", bus.bubble); end
    step();
    checks++; if (bus.hazard_err !== 1'b0) begin errors++; $display("FAIL rms_err: got %b want 0", bus.hazard_err); end
    checks++; if (bus.stall_total !== 32'd0) begin errors++; $display("FAIL rms_total: got %0d want 0", bus.stall_total); end
    checks++; if (bus4.stall_total !== 4'd0) begin errors++; $display("FAIL rms_total4: got %0d want 0", bus4.stall_total); end
    Rst = 1'b0;
  endtask

  task automatic test_saturation();
    hazard();
    repeat (15) step();
    checks++; if (bus4.stall_total !== 4'd15) begin errors++; $display("FAIL sat15_total4: got %0d want 15", bus4.stall_total); end
    checks++; if (bus.stall_total !== 32'd15) begin errors++; $display("FAIL sat15_total: got %0d want 15", bus.stall_total); end
    checks++; if (bus.hazard_err !== 1'b1) begin errors++; $display("FAIL sat_err: got %b want 1", bus.hazard_err); end
    repeat (5) step();
    checks++; if (bus4.stall_total !== 4'd15) begin errors++; $display("FAIL sat20_total4: got %0d want 15", bus4.stall_total); end
    checks++; if (bus.stall_total !== 32'd20) begin errors++; $display("FAIL sat20_total: got %0d want 20", bus.stall_total); end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int ep = 0; ep < 3; ep++) begin
      hazard();
      repeat (4) step();
      idle();
      step();
    end
    checks++; if (bus.hazard_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", bus.hazard_err); end
    checks++; if (bus.stall_total !== 32'd12) begin errors++; $display("FAIL b2b_total: got %0d want 12", bus.stall_total); end
    checks++; if (bus4.stall_total !== 4'd12) begin errors++; $display("FAIL b2b_total4: got %0d want 12", bus4.stall_total); end
  endtask

  initial begin
    idle();
    test_reset();
    test_youngest();
    test_reg0();
    test_load_use();
    test_same_stage();
    test_watchdog();
    test_reset_mid_stall();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
